// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths, state encoding and pointer helper for the
//               register file write-port arbiter and its selector.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int AW           = 5;
    localparam int DW           = 32;
    localparam int NREG         = 2 ** AW;
    localparam int NREQ_DEFAULT = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } wr_state_e;

    // Modulo add for a value already known to be below 2*n, so non-power-of-2
    // requester counts wrap correctly without a divider.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter_if
// Description : Requester-side request bus and register-file write bus of the
//               write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
);

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] wr_addr;
    logic [NREQ*DW-1:0] wr_data;
    logic               rf_stall;
    logic [NREQ-1:0]    gnt;
    logic               rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [DW-1:0]      rf_wdata;
    logic [2**AW-1:0]   rf_dec;

    modport master (
        output req, wr_addr, wr_data, rf_stall,
        input  gnt, rf_we, rf_waddr, rf_wdata, rf_dec
    );

    modport slave (
        input  req, wr_addr, wr_data, rf_stall,
        output gnt, rf_we, rf_waddr, rf_wdata, rf_dec
    );

endinterface
`default_nettype wire

// File: rtl/rr_priority_sel.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_sel
// Description : Combinational round-robin selector: rotate by ptr, pick the
//               first set bit, rotate back to a one-hot winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_sel
    import regfile_pkg::*;
#(
    parameter int N = 4
) (
    input  wire logic [N-1:0]                      elig,
    input  wire logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
    output logic      [N-1:0]                      win,
    output logic                                   valid
);

    localparam int c_pw = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] w_rot;
    logic [N-1:0] w_ffs;
    logic         w_found;

    always_comb begin
        w_rot   = '0;
        w_ffs   = '0;
        w_found = 1'b0;
        win     = '0;
        valid   = |elig;
        // w_rot[0] is the requester at ptr, so the lowest set bit is the winner.
        for (int i = 0; i < N; i++) begin
            w_rot[i] = elig[c_pw'(rr_wrap(int'(ptr) + i, N))];
        end
        for (int i = 0; i < N; i++) begin
            if (w_rot[i] && !w_found) begin
                w_found  = 1'b1;
                w_ffs[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            win[c_pw'(rr_wrap(int'(ptr) + i, N))] = w_ffs[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Round-robin arbiter sharing the single register-file write
//               port among NREQ requesters, with registered write outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int AW   = regfile_pkg::AW,
    parameter int DW   = regfile_pkg::DW
) (
    input wire logic            clk,
    input wire logic            rst,
    regfile_wr_arbiter_if.slave bus
);

    localparam int c_pw   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_nreg = 2 ** AW;

    wr_state_e          r_state, w_nxt_state;
    logic [c_pw-1:0]    r_ptr, w_nxt_ptr;
    logic [NREQ-1:0]    r_gnt, w_nxt_gnt;
    logic               r_we, w_nxt_we;
    logic [AW-1:0]      r_waddr, w_nxt_waddr;
    logic [DW-1:0]      r_wdata, w_nxt_wdata;
    logic [c_nreg-1:0]  r_dec, w_nxt_dec;

    logic [NREQ-1:0]    w_elig;
    logic [NREQ-1:0]    w_win;
    logic               w_valid;
    logic               w_grant;
    logic [c_pw-1:0]    w_win_idx;
    logic [AW-1:0]      w_win_addr;
    logic [DW-1:0]      w_win_data;

    // Outside ISSUE the grant register is zero, so only a just-granted
    // requester is ever masked.
    assign w_elig  = bus.req & ~((r_state == ISSUE) ? r_gnt : '0);
    assign w_grant = w_valid & ~bus.rf_stall;

    rr_priority_sel #(
        .N (NREQ)
    ) u_sel (
        .elig  (w_elig),
        .ptr   (r_ptr),
        .win   (w_win),
        .valid (w_valid)
    );

    always_comb begin
        w_win_idx  = '0;
        w_win_addr = '0;
        w_win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win[i]) begin
                w_win_idx  = c_pw'(i);
                w_win_addr = bus.wr_addr[i*AW +: AW];
                w_win_data = bus.wr_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        w_nxt_state = IDLE;
        w_nxt_ptr   = r_ptr;
        w_nxt_gnt   = '0;
        w_nxt_we    = 1'b0;
        w_nxt_waddr = r_waddr;
        w_nxt_wdata = r_wdata;
        w_nxt_dec   = '0;
        if (w_grant) begin
            w_nxt_state = ISSUE;
            w_nxt_gnt   = w_win;
            w_nxt_waddr = w_win_addr;
            w_nxt_wdata = w_win_data;
            w_nxt_ptr   = c_pw'(rr_wrap(int'(w_win_idx) + 1, NREQ));
            // Register 0 is hardwired zero: grant the slot but suppress the write.
            if (w_win_addr != '0) begin
                w_nxt_we  = 1'b1;
                w_nxt_dec = {{(c_nreg-1){1'b0}}, 1'b1} << w_win_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_dec   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_gnt   <= w_nxt_gnt;
            r_we    <= w_nxt_we;
            r_waddr <= w_nxt_waddr;
            r_wdata <= w_nxt_wdata;
            r_dec   <= w_nxt_dec;
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.rf_we    = r_we;
    assign bus.rf_waddr = r_waddr;
    assign bus.rf_wdata = r_wdata;
    assign bus.rf_dec   = r_dec;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Directed self-checking bench for regfile_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [AW-1:0] a [NREQ];
    logic [DW-1:0] d [NREQ];

    regfile_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    regfile_wr_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NREQ-1:0] r, input logic s);
        bus.req      = r;
        bus.rf_stall = s;
        for (int i = 0; i < NREQ; i++) begin
            bus.wr_addr[i*AW +: AW] = a[i];
            bus.wr_data[i*DW +: DW] = d[i];
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [NREQ-1:0] g,
                        input logic we, input logic [31:0] dec);
        chk({tag, ".gnt"}, 64'(bus.gnt), 64'(g));
        chk({tag, ".we"},  64'(bus.rf_we), 64'(we));
        chk({tag, ".dec"}, 64'(bus.rf_dec), 64'(dec));
    endtask

    initial begin
        a[0] = 5'd1;  a[1] = 5'd2;  a[2] = 5'd3;  a[3] = 5'd4;
        d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2; d[3] = 32'hA3;
        rst = 1'b1;
        drive(4'b1111, 1'b0);

        // Reset held three cycles with all requesters active
        for (int i = 0; i < 3; i++) begin
            tick();
            step("reset", 4'b0000, 1'b0, 32'h0);
            chk("reset.waddr", 64'(bus.rf_waddr), 64'h0);
            chk("reset.wdata", 64'(bus.rf_wdata), 64'h0);
        end
        rst = 1'b0;

        // Round-robin rotation starting at requester 0
        tick(); step("rr0", 4'b0001, 1'b1, 32'h2);
        chk("rr0.waddr", 64'(bus.rf_waddr), 64'd1);
        chk("rr0.wdata", 64'(bus.rf_wdata), 64'hA0);
        tick(); step("rr1", 4'b0010, 1'b1, 32'h4);
        chk("rr1.waddr", 64'(bus.rf_waddr), 64'd2);
        tick(); step("rr2", 4'b0100, 1'b1, 32'h8);
        chk("rr2.wdata", 64'(bus.rf_wdata), 64'hA2);
        tick(); step("rr3", 4'b1000, 1'b1, 32'h10);
        chk("rr3.waddr", 64'(bus.rf_waddr), 64'd4);
        tick(); step("rr4", 4'b0001, 1'b1, 32'h2);
        drive(4'b0000, 1'b0);
        tick(); step("idle0", 4'b0000, 1'b0, 32'h0);
        chk("idle0.waddr_hold", 64'(bus.rf_waddr), 64'd1);
        chk("idle0.wdata_hold", 64'(bus.rf_wdata), 64'hA0);

        // Single requester gets every other cycle
        a[2] = 5'd7; d[2] = 32'hDEADBEEF;
        drive(4'b0100, 1'b0);
        tick(); step("single0", 4'b0100, 1'b1, 32'h80);
        chk("single0.wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
        tick(); step("single1", 4'b0000, 1'b0, 32'h0);
        tick(); step("single2", 4'b0100, 1'b1, 32'h80);
        tick(); step("single3", 4'b0000, 1'b0, 32'h0);

        // Stall blocks arbitration; pointer (now 3) must not move
        drive(4'b0011, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(); step("stall", 4'b0000, 1'b0, 32'h0);
        end
        drive(4'b0011, 1'b0);
        tick(); step("unstall0", 4'b0001, 1'b1, 32'h2);
        tick(); step("unstall1", 4'b0010, 1'b1, 32'h4);
        drive(4'b0001, 1'b0);
        tick(); step("req0", 4'b0001, 1'b1, 32'h2);
        drive(4'b0000, 1'b0);
        tick(); step("idle1", 4'b0000, 1'b0, 32'h0);

        // Address zero winner: granted, but no write
        a[1] = 5'd0; d[1] = 32'h55; a[2] = 5'd9;
        drive(4'b0110, 1'b0);
        tick(); step("az0", 4'b0010, 1'b0, 32'h0);
        chk("az0.waddr", 64'(bus.rf_waddr), 64'd0);
        chk("az0.wdata", 64'(bus.rf_wdata), 64'h55);
        tick(); step("az1", 4'b0100, 1'b1, 32'h200);
        chk("az1.waddr", 64'(bus.rf_waddr), 64'd9);
        drive(4'b0000, 1'b0);
        tick(); step("idle2", 4'b0000, 1'b0, 32'h0);

        // Reset while requester 3 would win; restart must be from requester 0
        drive(4'b1111, 1'b0);
        rst = 1'b1;
        tick(); step("midrst", 4'b0000, 1'b0, 32'h0);
        chk("midrst.waddr", 64'(bus.rf_waddr), 64'h0);
        rst = 1'b0;
        tick(); step("post0", 4'b0001, 1'b1, 32'h2);
        tick(); step("post1", 4'b0010, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
